// File: rtl/c7bifu_fetch_ctrl_if.sv
// Fetch controller bus bundle: pipeline control, instruction-memory request/response, and IQ write.
// master is the fetch controller; slave is the surrounding pipeline, memory and IQ.
interface c7bifu_fetch_ctrl_if;
    logic        fetch_en;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_req_vld;
    logic [31:0] fetch_req_addr;
    logic        fetch_req_rdy;
    logic        fetch_resp_vld;
    logic [63:0] fetch_resp_data;
    logic        iq_data_vld;
    logic [31:0] iq_data_addr;
    logic [63:0] iq_data;
    logic        iq_flush;
    logic        iq_full;
    logic        fetch_busy;

    modport master (
        input  fetch_en, flush, flush_pc, fetch_req_rdy, fetch_resp_vld, fetch_resp_data, iq_full,
        output fetch_req_vld, fetch_req_addr, iq_data_vld, iq_data_addr, iq_data, iq_flush,
        output fetch_busy
    );

    modport slave (
        output fetch_en, flush, flush_pc, fetch_req_rdy, fetch_resp_vld, fetch_resp_data, iq_full,
        input  fetch_req_vld, fetch_req_addr, iq_data_vld, iq_data_addr, iq_data, iq_flush,
        input  fetch_busy
    );
endinterface

// File: rtl/c7bifu_fetch_ctrl.sv
// Fetch sequencer: one outstanding 8-byte-aligned fetch at a time, writes each returned
// doubleword into the IQ, and drops stale responses after a redirect.
module c7bifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
    input logic                   clk,
    input logic                   resetn,
    c7bifu_fetch_ctrl_if.master   bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_line;
    logic        unused_pc_bits;

    assign pc_line        = {pc_q[31:3], 3'b000};
    assign unused_pc_bits = ^pc_q[1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.flush) begin
                        pc_q <= bus.flush_pc;
                    end else if (bus.fetch_en && !bus.iq_full) begin
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (bus.flush) begin
                        pc_q    <= bus.flush_pc;
                        state_q <= StIdle;
                    end else if (bus.fetch_req_rdy) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (bus.flush) begin
                        pc_q    <= bus.flush_pc;
                        // Without a response this cycle, the in-flight one is still owed to us.
                        state_q <= bus.fetch_resp_vld ? StIdle : StDrop;
                    end else if (bus.fetch_resp_vld) begin
                        pc_q    <= pc_line + 32'd8;
                        state_q <= StIdle;
                    end
                end
                StDrop: begin
                    if (bus.flush) begin
                        pc_q <= bus.flush_pc;
                    end
                    if (bus.fetch_resp_vld) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.fetch_req_vld  = 1'b0;
        bus.fetch_req_addr = '0;
        bus.iq_data_vld    = 1'b0;
        bus.iq_data_addr   = '0;
        bus.iq_data        = '0;
        bus.iq_flush       = bus.flush;
        bus.fetch_busy     = (state_q != StIdle);

        if (state_q == StReq) begin
            bus.fetch_req_vld  = !bus.flush;
            bus.fetch_req_addr = pc_line;
        end

        if (state_q == StWait && bus.fetch_resp_vld && !bus.flush) begin
            bus.iq_data_vld  = 1'b1;
            bus.iq_data_addr = pc_line;
            // A fetch entered mid-doubleword must not execute the word before the target.
            bus.iq_data      = {bus.fetch_resp_data[63:32],
                                pc_q[2] ? NOP_INST : bus.fetch_resp_data[31:0]};
        end
    end

endmodule
